noc_write_packer: RTL



---
 rtl/noc_pkg.sv | 32 +++
 rtl/noc_word_fifo.sv | 49 ++++
 rtl/noc_write_packer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the write ingress path: command/rc codes,
// response opcode, receive state encoding and header field decoders.
package noc_pkg;

    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_WRITE = 3'b010;
    localparam logic [2:0] CMD_MSG   = 3'b101;

    localparam logic [1:0] RC_OK    = 2'b00;
    localparam logic [1:0] RC_ABORT = 2'b01;
    localparam logic [1:0] RC_OVF   = 2'b10;

    localparam logic [5:0] RSP_OPCODE = 6'b000100;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DEST,
        RX_SRC,
        RX_ADDR,
        RX_DATA,
        RX_SKIP
    } rx_state_t;

    function automatic logic [3:0] alen_bytes(input logic [1:0] f);
        return 4'd1 << f;
    endfunction

    function automatic logic [7:0] dlen_bytes(input logic [2:0] f);
        return 8'd1 << f;
    endfunction

endpackage

// File: rtl/noc_word_fifo.sv
// Small synchronous FIFO with show-ahead head; caller guarantees push only
// when not full (or popping) and pop only when not empty.
module noc_word_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW:0]                 wp_q, wp_d, rp_q, rp_d;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign rdata = mem_q[rp_q[AW-1:0]];

    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        if (push) begin
            mem_d[wp_q[AW-1:0]] = wdata;
            wp_d = wp_q + 1'b1;
        end
        if (pop) rp_d = rp_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
        end
    end

endmodule

// File: rtl/noc_write_packer.sv
// NoC write ingress: parses write commands, packs data bytes little-endian into
// words, buffers them and streams them out with block tagging; returns a response.
module noc_write_packer
    import noc_pkg::*;
#(
    parameter int WORD_W      = 64,
    parameter int BLOCK_BYTES = 200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              noc_to_dev_ctl,
    input  logic [7:0]        noc_to_dev_data,
    output logic              noc_from_dev_ctl,
    output logic [7:0]        noc_from_dev_data,
    output logic              pushin,
    output logic              firstin,
    input  logic              stopin,
    output logic [WORD_W-1:0] din
);

    localparam int B  = WORD_W / 8;
    localparam int IW = $clog2(B);
    localparam int CW = $clog2(BLOCK_BYTES);

    rx_state_t         st_q, st_d;
    logic [3:0]        alen_q, alen_d, acnt_q, acnt_d;
    logic [7:0]        dlen_q, dlen_d, dcnt_q, dcnt_d;
    logic [7:0]        src_q, src_d, dest_q, dest_d;
    logic              ovf_q, ovf_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     blk_q, blk_d;
    logic [WORD_W-1:0] res_q, res_d;
    logic [2:0][7:0]   rsp_q, rsp_d;
    logic [1:0]        rleft_q, rleft_d;
    logic              fctl_q, fctl_d;
    logic [7:0]        fdata_q, fdata_d;
    logic              pushin_q, pushin_d, firstin_q, firstin_d;
    logic [WORD_W-1:0] din_q, din_d;

    logic              byte_in, word_done, word_first, rsp_go, abort, drop, bypass;
    logic [7:0]        rsp_len;
    logic [1:0]        rc;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WORD_W:0]   fifo_rdata;

    always_comb begin
        st_d    = st_q;
        alen_d  = alen_q;
        acnt_d  = acnt_q;
        dlen_d  = dlen_q;
        dcnt_d  = dcnt_q;
        src_d   = src_q;
        dest_d  = dest_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        blk_d   = blk_q;
        res_d   = res_q;
        byte_in = 1'b0;
        rsp_go  = 1'b0;
        abort   = 1'b0;
        rsp_len = dcnt_q;

        // A header byte is always reparsed as a new command, even mid-command.
        if (noc_to_dev_ctl) begin
            abort  = (st_q == RX_DATA);
            rsp_go = abort;
            st_d   = (noc_to_dev_data[2:0] == CMD_WRITE) ? RX_DEST : RX_SKIP;
            alen_d = alen_bytes(noc_to_dev_data[7:6]);
            dlen_d = dlen_bytes(noc_to_dev_data[5:3]);
            acnt_d = '0;
            dcnt_d = '0;
            ovf_d  = 1'b0;
        end else begin
            case (st_q)
                RX_DEST: if (noc_to_dev_data == 8'h00) st_d = RX_SKIP;
                         else begin dest_d = noc_to_dev_data; st_d = RX_SRC; end
                RX_SRC:  if (noc_to_dev_data == 8'h00) st_d = RX_SKIP;
                         else begin src_d = noc_to_dev_data; st_d = RX_ADDR; end
                RX_ADDR: begin
                    acnt_d = acnt_q + 4'd1;
                    if (acnt_d == alen_q) st_d = RX_DATA;
                end
                RX_DATA: begin
                    byte_in = 1'b1;
                    dcnt_d  = dcnt_q + 8'd1;
                    if (dcnt_d == dlen_q) begin
                        rsp_go  = 1'b1;
                        rsp_len = dcnt_d;
                        st_d    = RX_IDLE;
                    end
                end
                default: ;
            endcase
        end

        word_done  = 1'b0;
        word_first = 1'b0;
        if (byte_in) begin
            res_d[8*int'(idx_q) +: 8] = noc_to_dev_data;
            blk_d = (blk_q == CW'(BLOCK_BYTES-1)) ? '0 : blk_q + 1'b1;
            if (idx_q == IW'(B-1)) begin
                word_done  = 1'b1;
                word_first = (blk_q == CW'(B-1));
                idx_d      = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        // Output register loads only while not stalled; an empty FIFO lets a
        // freshly completed word go straight to the output.
        fifo_pop  = !stopin && !fifo_empty;
        bypass    = !stopin && fifo_empty && word_done;
        fifo_push = word_done && !bypass && (!fifo_full || fifo_pop);
        drop      = word_done && !bypass && fifo_full && !fifo_pop;
        if (drop) ovf_d = 1'b1;

        pushin_d  = pushin_q;
        firstin_d = firstin_q;
        din_d     = din_q;
        if (!stopin) begin
            pushin_d  = !fifo_empty || word_done;
            firstin_d = 1'b0;
            if (!fifo_empty) begin
                {firstin_d, din_d} = fifo_rdata;
            end else if (word_done) begin
                firstin_d = word_first;
                din_d     = res_d;
            end
        end

        rc      = abort ? RC_ABORT : ((ovf_q || drop) ? RC_OVF : RC_OK);
        fctl_d  = 1'b0;
        fdata_d = 8'h00;
        rsp_d   = rsp_q;
        rleft_d = rleft_q;
        if (rsp_go) begin
            fctl_d  = 1'b1;
            fdata_d = {rc, RSP_OPCODE};
            rsp_d   = {rsp_len, dest_q, src_q};
            rleft_d = 2'd3;
        end else if (rleft_q != 2'd0) begin
            fdata_d = rsp_q[0];
            rsp_d   = {8'h00, rsp_q[2:1]};
            rleft_d = rleft_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q      <= RX_IDLE;
            alen_q    <= '0;
            acnt_q    <= '0;
            dlen_q    <= '0;
            dcnt_q    <= '0;
            src_q     <= '0;
            dest_q    <= '0;
            ovf_q     <= 1'b0;
            idx_q     <= '0;
            blk_q     <= '0;
            res_q     <= '0;
            rsp_q     <= '0;
            rleft_q   <= '0;
            fctl_q    <= 1'b0;
            fdata_q   <= '0;
            pushin_q  <= 1'b0;
            firstin_q <= 1'b0;
            din_q     <= '0;
        end else begin
            st_q      <= st_d;
            alen_q    <= alen_d;
            acnt_q    <= acnt_d;
            dlen_q    <= dlen_d;
            dcnt_q    <= dcnt_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            ovf_q     <= ovf_d;
            idx_q     <= idx_d;
            blk_q     <= blk_d;
            res_q     <= res_d;
            rsp_q     <= rsp_d;
            rleft_q   <= rleft_d;
            fctl_q    <= fctl_d;
            fdata_q   <= fdata_d;
            pushin_q  <= pushin_d;
            firstin_q <= firstin_d;
            din_q     <= din_d;
        end
    end

    noc_word_fifo #(
        .WIDTH(WORD_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({word_first, res_d}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign noc_from_dev_ctl  = fctl_q;
    assign noc_from_dev_data = fdata_q;
    assign pushin            = pushin_q;
    assign firstin           = firstin_q;
    assign din               = din_q;

endmodule
